// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD_IF,
    WAIT_IF,
    CMD_D,
    WAIT_D,
    DONE
  } state_t;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data requesters, with a starvation
// counter that forces a fetch grant after STARVE_LIMIT data grants.
module mem_arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic if_req,
  input  logic d_req,
  output logic grant,
  output logic grant_d
);

  logic [2:0] starve_cnt;
  logic       starved;

  assign starved = 32'(starve_cnt) >= STARVE_LIMIT;

  always_comb begin
    grant   = sample && (if_req || d_req);
    grant_d = d_req && !(if_req && starved);
  end

  // Only counts grants that actually leave IDLE; a fetch grant or an idle
  // fetch requester both restart the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (sample) begin
      if (!if_req || !grant_d) begin
        starve_cnt <= '0;
      end else if (starve_cnt != 3'd7) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) arbiter onto a single request/accept/complete
// memory port; one transaction outstanding at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic        IF_VALID,
  output logic [31:0] IF_RDATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  input  logic [2:0]  D_FUNC3,
  output logic        D_VALID,
  output logic [31:0] D_RDATA,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  output logic [2:0]  M_FUNC3,
  input  logic        M_READY,
  input  logic        M_RVALID,
  input  logic [31:0] M_RDATA,
  output logic        PROTO_ERR
);

  state_t state;
  logic   grant;
  logic   grant_d;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk    (CLK),
    .rst_n  (RST),
    .sample (state == IDLE),
    .if_req (IF_REQ),
    .d_req  (D_REQ),
    .grant  (grant),
    .grant_d(grant_d)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      M_REQ     <= 1'b0;
      M_WE      <= 1'b0;
      M_ADDR    <= '0;
      M_WDATA   <= '0;
      M_FUNC3   <= '0;
      IF_VALID  <= 1'b0;
      D_VALID   <= 1'b0;
      IF_RDATA  <= '0;
      D_RDATA   <= '0;
      PROTO_ERR <= 1'b0;
    end else begin
      IF_VALID <= 1'b0;
      D_VALID  <= 1'b0;
      if (M_RVALID && state != WAIT_IF && state != WAIT_D) begin
        PROTO_ERR <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (grant) begin
            M_REQ <= 1'b1;
            if (grant_d) begin
              state   <= CMD_D;
              M_WE    <= D_WE;
              M_ADDR  <= D_ADDR;
              M_WDATA <= D_WDATA;
              M_FUNC3 <= D_FUNC3;
            end else begin
              state   <= CMD_IF;
              M_WE    <= 1'b0;
              M_ADDR  <= IF_ADDR;
              M_WDATA <= '0;
              M_FUNC3 <= F3_LW;
            end
          end
        end
        CMD_IF: begin
          if (M_READY) begin
            M_REQ <= 1'b0;
            state <= WAIT_IF;
          end
        end
        CMD_D: begin
          if (M_READY) begin
            M_REQ <= 1'b0;
            state <= WAIT_D;
          end
        end
        WAIT_IF: begin
          if (M_RVALID) begin
            IF_RDATA <= M_RDATA;
            IF_VALID <= 1'b1;
            state    <= DONE;
          end
        end
        WAIT_D: begin
          // M_WE still holds the granted command, so stores leave D_RDATA alone
          if (M_RVALID) begin
            if (!M_WE) begin
              D_RDATA <= M_RDATA;
            end
            D_VALID <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester and memory models, an
// arbitration reference and a monitor that checks every completion and grant.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IF_REQ, D_REQ, D_WE, M_READY, M_RVALID;
  logic [31:0] IF_ADDR, D_ADDR, D_WDATA, M_RDATA;
  logic [2:0]  D_FUNC3;
  logic        IF_VALID, D_VALID, M_REQ, M_WE, PROTO_ERR;
  logic [31:0] IF_RDATA, D_RDATA, M_ADDR, M_WDATA;
  logic [2:0]  M_FUNC3;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_VALID(IF_VALID), .IF_RDATA(IF_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_FUNC3(D_FUNC3),
    .D_VALID(D_VALID), .D_RDATA(D_RDATA),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_FUNC3(M_FUNC3),
    .M_READY(M_READY), .M_RVALID(M_RVALID), .M_RDATA(M_RDATA),
    .PROTO_ERR(PROTO_ERR)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
  } dreq_t;

  logic [31:0] if_todo[$];
  dreq_t       d_todo[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];
  bit          grant_log[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] last_d = '0;

  int checks = 0;
  int errors = 0;
  int unsigned ready_mode = 1, lat_max = 1, gap_max = 0;
  bit drop_resp = 1'b0;
  int inject_req = 0, inject_ack = 0, abort_req = 0, abort_ack = 0;
  int accept_cnt = 0, cyc = 0;
  int if_issue_cyc = 0, grant_cyc = 0, if_valid_cyc = 0, last_run = 0;
  logic smp_if = 1'b0, smp_d = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge CLK) begin
    smp_if <= IF_REQ;
    smp_d  <= D_REQ;
    cyc    <= cyc + 1;
  end

  // Fetch requester: holds the request until IF_VALID, then issues the next.
  initial begin : if_requester
    int unsigned gap;
    logic [31:0] a;
    IF_REQ = 1'b0; IF_ADDR = '0; gap = 0;
    forever begin
      @(posedge CLK); #1;
      if (IF_REQ && IF_VALID) IF_REQ = 1'b0;
      if (!IF_REQ && if_todo.size() > 0) begin
        if (gap > 0) gap--;
        else begin
          a = if_todo.pop_front();
          IF_ADDR = a; IF_REQ = 1'b1;
          exp_if.push_back(mem_word(a));
          if_issue_cyc = cyc;
          gap = $urandom_range(0, gap_max);
        end
      end
    end
  end

  // Data requester: expected load data comes from the memory image; a store
  // expects D_RDATA to keep the last loaded value.
  initial begin : d_requester
    int unsigned gap;
    dreq_t t;
    D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0; D_FUNC3 = '0; gap = 0;
    forever begin
      @(posedge CLK); #1;
      if (abort_req != abort_ack) begin
        abort_ack = abort_req;
        if (D_REQ) begin
          D_REQ = 1'b0;
          void'(exp_d.pop_back());
        end
      end
      if (D_REQ && D_VALID) D_REQ = 1'b0;
      if (!D_REQ && d_todo.size() > 0) begin
        if (gap > 0) gap--;
        else begin
          t = d_todo.pop_front();
          D_WE = t.we; D_ADDR = t.addr; D_WDATA = t.wdata; D_FUNC3 = t.func3; D_REQ = 1'b1;
          if (!t.we) last_d = mem_word(t.addr);
          exp_d.push_back(last_d);
          gap = $urandom_range(0, gap_max);
        end
      end
    end
  end

  // Memory: accepts one command, completes it 1..lat_max cycles later.
  initial begin : mem_model
    int unsigned stall, lat;
    logic        we;
    logic [31:0] addr, wdata;
    M_READY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; stall = 0;
    forever begin
      @(posedge CLK);
      if (RST && M_REQ && M_READY) begin
        we = M_WE; addr = M_ADDR; wdata = M_WDATA;
        accept_cnt++;
        lat = $urandom_range(1, lat_max);
        #1 M_READY = 1'b0;
        repeat (lat - 1) begin @(posedge CLK); #1; end
        if (!drop_resp) begin
          M_RDATA = we ? $urandom : mem_word(addr);
          if (we) mem[addr] = wdata;
          M_RVALID = 1'b1;
          @(posedge CLK); #1 M_RVALID = 1'b0;
        end
        stall = 0;
      end else begin
        #1;
        if (inject_ack != inject_req) begin
          inject_ack = inject_req;
          M_RVALID = 1'b1;
          M_RDATA  = 32'hBAD0_BAD0;
        end else begin
          M_RVALID = 1'b0;
        end
        stall = M_REQ ? stall + 1 : 0;
        case (ready_mode)
          0:       M_READY = 1'($urandom_range(0, 1));
          1:       M_READY = 1'b1;
          default: M_READY = (stall >= 4);
        endcase
      end
    end
  end

  // Monitor: completions against the scoreboard, grants against the
  // arbitration rules (data first unless IF waited through LIMIT data grants).
  initial begin : monitor
    bit mreq_prev, exp_own_d;
    int unsigned starve;
    int run;
    logic [67:0] snap;
    mreq_prev = 1'b0; starve = 0; run = 0; snap = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        mreq_prev = 1'b0; starve = 0; run = 0;
        continue;
      end
      if (IF_VALID || D_VALID) chk("valid_exclusive", 1'(IF_VALID & D_VALID), 1'b0);
      if (IF_VALID) begin
        if (exp_if.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_unexpected: got IF_VALID with rdata %0h, expected none", IF_RDATA);
        end else begin
          if_valid_cyc = cyc;
          chk("if_rdata", IF_RDATA, exp_if.pop_front());
        end
      end
      if (D_VALID) begin
        if (exp_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_unexpected: got D_VALID with rdata %0h, expected none", D_RDATA);
        end else begin
          chk("d_rdata", D_RDATA, exp_d.pop_front());
        end
      end
      if (M_REQ && !mreq_prev) begin
        if (!(smp_if || smp_d)) begin
          checks++; errors++;
          $display("FAIL grant_noreq: got M_REQ at addr %0h, expected no request", M_ADDR);
        end
        exp_own_d = smp_d && !(smp_if && starve >= LIMIT);
        if (exp_own_d)
          chk("grant_d_cmd", {M_WE, M_ADDR, M_WDATA, M_FUNC3}, {D_WE, D_ADDR, D_WDATA, D_FUNC3});
        else
          chk("grant_if_cmd", {M_WE, M_ADDR}, {1'b0, IF_ADDR});
        starve = (!exp_own_d || !smp_if) ? 0 : ((starve < 7) ? starve + 1 : 7);
        grant_log.push_back(exp_own_d);
        grant_cyc = cyc;
        snap = {M_WE, M_ADDR, M_WDATA, M_FUNC3};
        run = 0;
      end
      if (M_REQ) begin
        run++;
        if (mreq_prev) chk("cmd_stable", {M_WE, M_ADDR, M_WDATA, M_FUNC3}, snap);
      end
      if (!M_REQ && mreq_prev) last_run = run;
      mreq_prev = M_REQ;
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((if_todo.size() + d_todo.size() + exp_if.size() + exp_d.size() > 0 ||
            IF_REQ || D_REQ) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending after %0d cycles, expected 0",
               exp_if.size() + exp_d.size(), budget);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_cmd"}, {M_REQ, M_WE, M_ADDR, M_WDATA, M_FUNC3}, '0);
    chk({tag, "_rsp"}, {IF_VALID, D_VALID, IF_RDATA, D_RDATA, PROTO_ERR}, '0);
  endtask

  initial begin : main
    logic [6:0] seq;
    dreq_t t;
    int n, k;
    #1 RST = 1'b0;
    repeat (2) @(negedge CLK);
    check_outputs_zero("reset_state");
    RST = 1'b1;

    // IF-only fetch with an immediate memory
    mem[32'h100] = 32'h0050_0093;
    if_todo.push_back(32'h100);
    wait_drain(50);
    chk("if_grant_latency", 128'(grant_cyc - if_issue_cyc), 128'd1);
    chk("if_valid_latency", 128'(if_valid_cyc - if_issue_cyc), 128'd3);

    // Simultaneous fetch and load: data first
    grant_log.delete();
    @(negedge CLK);
    if_todo.push_back(32'h104);
    d_todo.push_back('{we: 1'b0, addr: 32'h2000, wdata: '0, func3: F3_LW});
    wait_drain(50);
    chk("simul_count", 128'(grant_log.size()), 128'd2);
    if (grant_log.size() == 2) chk("simul_order", {grant_log[0], grant_log[1]}, 2'b10);

    // Starvation guard: IF gets in after LIMIT back-to-back data grants
    grant_log.delete();
    @(negedge CLK);
    if_todo.push_back(32'h108);
    for (int i = 0; i < 6; i++)
      d_todo.push_back('{we: 1'b0, addr: 32'h2100 + 32'(4 * i), wdata: '0, func3: F3_LW});
    wait_drain(200);
    chk("starve_count", 128'(grant_log.size()), 128'd7);
    if (grant_log.size() == 7) begin
      for (int i = 0; i < 7; i++) seq[6 - i] = grant_log[i];
      chk("starve_seq", seq, 7'b1111011);
    end

    // Backpressure on a store: command held for four cycles
    ready_mode = 2;
    d_todo.push_back('{we: 1'b1, addr: 32'h10, wdata: 32'hDEAD_BEEF, func3: F3_SW});
    wait_drain(50);
    chk("bp_hold_cycles", 128'(last_run), 128'd4);

    // Randomized traffic
    ready_mode = 0; lat_max = 3; gap_max = 3;
    for (int i = 0; i < 40; i++) begin
      if_todo.push_back(32'h1000 + 32'(4 * $urandom_range(0, 255)));
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = 32'h4000 + 32'(4 * $urandom_range(0, 15));
      t.wdata = $urandom;
      t.func3 = 3'($urandom_range(0, 7));
      d_todo.push_back(t);
    end
    wait_drain(5000);

    // Reset during WAIT_D abandons the load
    ready_mode = 1; lat_max = 1; gap_max = 0; drop_resp = 1'b1;
    n = accept_cnt; k = 0;
    d_todo.push_back('{we: 1'b0, addr: 32'h3000, wdata: '0, func3: F3_LW});
    while (accept_cnt == n && k < 50) begin @(negedge CLK); k++; end
    chk("abort_accepted", 128'(accept_cnt - n), 128'd1);
    abort_req++;
    #1 RST = 1'b0;
    #1 check_outputs_zero("reset_mid_wait");
    last_d = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    drop_resp = 1'b0;
    repeat (5) @(negedge CLK);
    chk("abort_no_pending", 128'(exp_d.size()), 128'd0);

    // Stray completion in IDLE sets a sticky error
    chk("proto_clear", PROTO_ERR, 1'b0);
    inject_req++;
    repeat (3) @(negedge CLK);
    chk("proto_set", PROTO_ERR, 1'b1);
    repeat (5) @(negedge CLK);
    chk("proto_held", PROTO_ERR, 1'b1);
    RST = 1'b0;
    #1 chk("proto_reset", PROTO_ERR, 1'b0);
    @(negedge CLK);
    RST = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
